// File: rtl/multicycle_control_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, ALU codes and FSM states shared by multicycle_control.
// Optional multiplier support (MULTU_EN) adds the MULWAIT state and the mfhi/mflo ALU code.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLTU  = 6'h2B;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULTU = 6'h19;

   typedef enum logic [2:0] {
      ALU_SLTU  = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_UNDEF = 3'b010,
      ALU_LUI   = 3'b011,
      ALU_ADD   = 3'b101,
      ALU_OR    = 3'b110,
      ALU_AND   = 3'b111
`ifdef MULTU_EN
      , ALU_MFHL = 3'b100
`endif
   } alu_op_e;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
`ifdef MULTU_EN
      , S_MULWAIT = 3'd5
`endif
   } state_e;

   function automatic logic known_opcode(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDIU,
         OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// alu_decode: R-type funct field to ALU operation, flagging functs this core does not implement.
// With MULTU_EN, mfhi/mflo map to ALU_MFHL and multu is accepted (no ALU operation).
module alu_decode
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 3
) (
   input  logic [5:0]           funct_i,
   output logic [ALUCTRL_W-1:0] alucontrol_o,
   output logic                 illegal_funct_o
);

   always_comb begin
      alucontrol_o    = ALUCTRL_W'(ALU_UNDEF);
      illegal_funct_o = 1'b0;
      case (funct_i)
         FN_ADDU: alucontrol_o = ALUCTRL_W'(ALU_ADD);
         FN_SUBU: alucontrol_o = ALUCTRL_W'(ALU_SUB);
         FN_AND:  alucontrol_o = ALUCTRL_W'(ALU_AND);
         FN_OR:   alucontrol_o = ALUCTRL_W'(ALU_OR);
         FN_SLTU: alucontrol_o = ALUCTRL_W'(ALU_SLTU);
`ifdef MULTU_EN
         FN_MFHI, FN_MFLO: alucontrol_o = ALUCTRL_W'(ALU_MFHL);
         FN_MULTU:         alucontrol_o = ALUCTRL_W'(ALU_UNDEF);
`endif
         default: illegal_funct_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with mem_ready timeout, JAL link and illegal trap.
// Define MULTU_EN to add multu/mfhi/mflo, the mul_start/mul_done handshake and the MULWAIT state.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W   = 3,
   parameter int unsigned REGADDR_W   = 5,
   parameter int unsigned LINK_REG    = 31,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 mem_ready,
`ifdef MULTU_EN
   input  logic                 mul_done,
   output logic                 mul_start,
`endif
   output logic                 memread,
   output logic                 memwrite,
   output logic                 iord,
   output logic                 irwrite,
   output logic                 pcwrite,
   output logic                 dobranch,
   output logic                 dojump,
   output logic                 alusrcbimm,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 regwrite,
   output logic [REGADDR_W-1:0] destreg,
   output logic                 memtoreg,
   output logic                 linksel,
   output logic                 illegal,
   output logic                 buserr
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     tcnt_q, tcnt_d;
   logic [5:0]           opcode, funct;
   logic                 is_rtype, illegal_instr, mem_wait, timeout;
   logic [ALUCTRL_W-1:0] rfunct_alu, instr_alu;
   logic                 rfunct_illegal, instr_imm;
   logic                 unused_instr_bits;

   assign opcode            = instr[31:26];
   assign funct             = instr[5:0];
   assign is_rtype          = (opcode == OP_RTYPE);
   assign illegal_instr     = !known_opcode(opcode) || (is_rtype && rfunct_illegal);
   assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

   alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
      .funct_i         (funct),
      .alucontrol_o    (rfunct_alu),
      .illegal_funct_o (rfunct_illegal)
   );

   // ALU setup shared by EXEC and WB so the operation stays stable through write-back
   always_comb begin
      instr_alu = ALUCTRL_W'(ALU_UNDEF);
      instr_imm = 1'b0;
      case (opcode)
         OP_RTYPE:             instr_alu = rfunct_alu;
         OP_ADDIU, OP_LW, OP_SW: begin
            instr_alu = ALUCTRL_W'(ALU_ADD);
            instr_imm = 1'b1;
         end
         OP_ORI: begin
            instr_alu = ALUCTRL_W'(ALU_OR);
            instr_imm = 1'b1;
         end
         OP_LUI: begin
            instr_alu = ALUCTRL_W'(ALU_LUI);
            instr_imm = 1'b1;
         end
         OP_BEQ:               instr_alu = ALUCTRL_W'(ALU_SUB);
         default: ;
      endcase
   end

   assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
   assign timeout  = mem_wait && (MEM_TIMEOUT != 0) && (tcnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      dobranch   = 1'b0;
      dojump     = 1'b0;
      alusrcbimm = 1'b0;
      alucontrol = ALUCTRL_W'(ALU_UNDEF);
      regwrite   = 1'b0;
      destreg    = '0;
      memtoreg   = 1'b0;
      linksel    = 1'b0;
      illegal    = 1'b0;
      buserr     = 1'b0;
`ifdef MULTU_EN
      mul_start  = 1'b0;
`endif
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               memread = 1'b1;
               if (mem_ready) begin
                  irwrite = 1'b1;
                  pcwrite = 1'b1;
                  state_d = S_DECODE;
               end else if (timeout) begin
                  buserr  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_DECODE: begin
               state_d = S_EXEC;
               if (illegal_instr) begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end else if (opcode == OP_J) begin
                  dojump  = 1'b1;
                  state_d = S_FETCH;
               end else if (opcode == OP_JAL) begin
                  dojump   = 1'b1;
                  regwrite = 1'b1;
                  destreg  = REGADDR_W'(LINK_REG);
                  linksel  = 1'b1;
                  state_d  = S_FETCH;
               end
            end
            S_EXEC: begin
               alucontrol = instr_alu;
               alusrcbimm = instr_imm;
               state_d    = S_WB;
               case (opcode)
                  OP_BEQ: begin
                     dobranch = zero;
                     state_d  = S_FETCH;
                  end
                  OP_LW, OP_SW: state_d = S_MEM;
`ifdef MULTU_EN
                  OP_RTYPE: begin
                     if (funct == FN_MULTU) begin
                        mul_start = 1'b1;
                        state_d   = S_MULWAIT;
                     end
                  end
`endif
                  default: ;
               endcase
            end
            S_MEM: begin
               iord       = 1'b1;
               alusrcbimm = 1'b1;
               alucontrol = ALUCTRL_W'(ALU_ADD);
               if (opcode == OP_SW) memwrite = 1'b1;
               else                 memread  = 1'b1;
               if (mem_ready) begin
                  state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
               end else if (timeout) begin
                  buserr  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_WB: begin
               regwrite   = 1'b1;
               alucontrol = instr_alu;
               destreg    = is_rtype ? REGADDR_W'(instr[15:11]) : REGADDR_W'(instr[20:16]);
               memtoreg   = (opcode == OP_LW);
               state_d    = S_FETCH;
            end
`ifdef MULTU_EN
            S_MULWAIT: begin
               if (mul_done) state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

   // A timeout retry stays in FETCH, so it must clear the counter explicitly
   always_comb begin
      tcnt_d = tcnt_q;
      if ((state_d != state_q) || timeout) tcnt_d = '0;
      else if (mem_wait && (MEM_TIMEOUT != 0)) tcnt_d = tcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenarios plus randomized instruction/mem_ready/reset traffic,
// checked every cycle against a phase-list model of the multicycle control unit.
module tb_multicycle_control;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset, zero, mem_ready;
   logic [31:0] instr;
   logic        memread, memwrite, iord, irwrite, pcwrite, dobranch, dojump, alusrcbimm;
   logic [2:0]  alucontrol;
   logic        regwrite;
   logic [4:0]  destreg;
   logic        memtoreg, linksel, illegal, buserr;

   always #5 clk = ~clk;

   multicycle_control #(
      .ALUCTRL_W   (3),
      .REGADDR_W   (5),
      .LINK_REG    (31),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .memread    (memread),
      .memwrite   (memwrite),
      .iord       (iord),
      .irwrite    (irwrite),
      .pcwrite    (pcwrite),
      .dobranch   (dobranch),
      .dojump     (dojump),
      .alusrcbimm (alusrcbimm),
      .alucontrol (alucontrol),
      .regwrite   (regwrite),
      .destreg    (destreg),
      .memtoreg   (memtoreg),
      .linksel    (linksel),
      .illegal    (illegal),
      .buserr     (buserr)
   );

   typedef struct packed {
      logic memread, memwrite, iord, irwrite, pcwrite, dobranch, dojump, alusrcbimm;
      logic regwrite, memtoreg, linksel, illegal, buserr;
   } strobes_t;

   typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W} ph_e;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cycle_no = 0;
   int          waitc = 0;
   int          burst = 0;
   ph_e         plan[$];
   logic [31:0] prog[$];
   logic [31:0] pending_instr;
   logic        load_pending = 1'b0;

   function automatic logic legal(input logic [31:0] w);
      case (w[31:26])
         6'h00: return w[5:0] inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
         6'h02, 6'h03, 6'h04, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] alu_of(input logic [31:0] w);
      case (w[31:26])
         6'h00: begin
            case (w[5:0])
               6'h21:   return 3'b101;
               6'h23:   return 3'b001;
               6'h24:   return 3'b111;
               6'h25:   return 3'b110;
               6'h2B:   return 3'b000;
               default: return 3'b010;
            endcase
         end
         6'h09, 6'h23, 6'h2B: return 3'b101;
         6'h0D:               return 3'b110;
         6'h0F:               return 3'b011;
         6'h04:               return 3'b001;
         default:             return 3'b010;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 11))
         0, 11: begin
            w[31:26] = 6'h00;
            case ($urandom_range(0, 4))
               0: w[5:0] = 6'h21;
               1: w[5:0] = 6'h23;
               2: w[5:0] = 6'h24;
               3: w[5:0] = 6'h25;
               default: w[5:0] = 6'h2B;
            endcase
         end
         1: begin
            w[31:26] = 6'h00;
            case ($urandom_range(0, 4))
               0: w[5:0] = 6'h19;
               1: w[5:0] = 6'h10;
               2: w[5:0] = 6'h00;
               3: w[5:0] = 6'h2A;
               default: w[5:0] = 6'h3F;
            endcase
         end
         2:  w[31:26] = 6'h09;
         3:  w[31:26] = 6'h0D;
         4:  w[31:26] = 6'h0F;
         5:  w[31:26] = 6'h23;
         6:  w[31:26] = 6'h2B;
         7:  w[31:26] = 6'h04;
         8:  w[31:26] = 6'h02;
         9:  w[31:26] = 6'h03;
         default: begin
            case ($urandom_range(0, 4))
               0: w[31:26] = 6'h3F;
               1: w[31:26] = 6'h01;
               2: w[31:26] = 6'h08;
               3: w[31:26] = 6'h20;
               default: w[31:26] = 6'h1C;
            endcase
         end
      endcase
      return w;
   endfunction

   // Phases an instruction visits after its fetch completes
   task automatic plan_for(input logic [31:0] w);
      plan.delete();
      plan.push_back(PH_D);
      if (legal(w) && w[31:26] != 6'h02 && w[31:26] != 6'h03) begin
         plan.push_back(PH_E);
         if (w[31:26] == 6'h23) begin
            plan.push_back(PH_M);
            plan.push_back(PH_W);
         end else if (w[31:26] == 6'h2B) begin
            plan.push_back(PH_M);
         end else if (w[31:26] != 6'h04) begin
            plan.push_back(PH_W);
         end
      end
   endtask

   task automatic model(input logic r, input logic mr, input logic z,
                        output strobes_t s, output logic [2:0] alu, output logic chk_alu,
                        output logic [4:0] dst);
      logic [5:0] op;
      logic       tmo;
      ph_e        ph;
      s       = '0;
      alu     = 3'b010;
      dst     = 5'd0;
      chk_alu = 1'b0;
      op      = instr[31:26];
      if (r) begin
         chk_alu = 1'b1;
         plan.delete();
         plan.push_back(PH_F);
         waitc = 0;
      end else begin
         ph  = plan[0];
         tmo = (ph == PH_F || ph == PH_M) && !mr && (TMO != 0) && (waitc == TMO - 1);
         case (ph)
            PH_F: begin
               s.memread = 1'b1;
               s.irwrite = mr;
               s.pcwrite = mr;
            end
            PH_D: begin
               if (!legal(instr)) s.illegal = 1'b1;
               else if (op == 6'h02) s.dojump = 1'b1;
               else if (op == 6'h03) begin
                  s.dojump   = 1'b1;
                  s.regwrite = 1'b1;
                  s.linksel  = 1'b1;
                  dst        = 5'd31;
               end
            end
            PH_E: begin
               chk_alu      = 1'b1;
               alu          = alu_of(instr);
               s.alusrcbimm = op inside {6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B};
               if (op == 6'h04) s.dobranch = z;
            end
            PH_M: begin
               chk_alu      = 1'b1;
               alu          = 3'b101;
               s.iord       = 1'b1;
               s.alusrcbimm = 1'b1;
               if (op == 6'h2B) s.memwrite = 1'b1;
               else             s.memread  = 1'b1;
            end
            default: begin
               chk_alu    = 1'b1;
               alu        = alu_of(instr);
               s.regwrite = 1'b1;
               s.memtoreg = (op == 6'h23);
               dst        = (op == 6'h00) ? instr[15:11] : instr[20:16];
            end
         endcase
         s.buserr = tmo;
         if (tmo) begin
            plan.delete();
            plan.push_back(PH_F);
            waitc = 0;
         end else if ((ph == PH_F || ph == PH_M) && !mr) begin
            waitc++;
         end else begin
            waitc = 0;
            void'(plan.pop_front());
            if (ph == PH_F) begin
               pending_instr = (prog.size() > 0) ? prog.pop_front() : rand_instr();
               load_pending  = 1'b1;
               plan_for(pending_instr);
            end
            if (plan.size() == 0) plan.push_back(PH_F);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic mr, input logic z);
      strobes_t   es, as;
      logic [2:0] ealu;
      logic       chk_alu;
      logic [4:0] edst;
      @(negedge clk);
      if (load_pending) begin
         instr        = pending_instr;
         load_pending = 1'b0;
      end
      reset     = r;
      mem_ready = mr;
      zero      = z;
      #1;
      model(r, mr, z, es, ealu, chk_alu, edst);
      as = {memread, memwrite, iord, irwrite, pcwrite, dobranch, dojump, alusrcbimm,
            regwrite, memtoreg, linksel, illegal, buserr};
      n_tests++;
      if (as !== es) begin
         n_fail++;
         $display("FAIL strobes cycle %0d instr %h: got %b want %b (memread..buserr)",
                  cycle_no, instr, as, es);
      end
      if (chk_alu) begin
         n_tests++;
         if (alucontrol !== ealu) begin
            n_fail++;
            $display("FAIL alucontrol cycle %0d instr %h: got %b want %b", cycle_no, instr, alucontrol, ealu);
         end
      end
      if (r || es.regwrite) begin
         n_tests++;
         if (destreg !== edst) begin
            n_fail++;
            $display("FAIL destreg cycle %0d instr %h: got %0d want %0d", cycle_no, instr, destreg, edst);
         end
      end
      cycle_no++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   initial begin
      int memread_cnt;
      reset     = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      instr     = 32'h0;
      prog.push_back(32'h00221821);  // addu $3,$1,$2
      prog.push_back(32'h8C850008);  // lw   $5,8($4)
      prog.push_back(32'h10220004);  // beq  $1,$2,4
      prog.push_back(32'h10220004);
      prog.push_back(32'h0C400010);  // jal  0x0400010
      prog.push_back(32'hFC000000);  // opcode 0x3F
      prog.push_back(32'hAC220004);  // sw   $2,4($1)

      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("reset_memread", 32'(memread), 32'd0);
      chk("reset_alucontrol", 32'(alucontrol), 32'b010);

      // addu: F D E W
      cyc(1'b0, 1'b1, 1'b0);
      chk("addu_fetch_irwrite", 32'(irwrite), 32'd1);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("addu_wb_regwrite", 32'(regwrite), 32'd1);
      chk("addu_wb_destreg", 32'(destreg), 32'd3);
      chk("addu_wb_alucontrol", 32'(alucontrol), 32'b101);

      // lw with three stalled MEM cycles
      cyc(1'b0, 1'b1, 1'b0);
      chk("addu_back_in_fetch", 32'(memread & ~iord), 32'd1);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      memread_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, (i == 3), 1'b0);
         if (memread && iord) memread_cnt++;
      end
      chk("lw_mem_memread_cycles", 32'(memread_cnt), 32'd4);
      cyc(1'b0, 1'b1, 1'b0);
      chk("lw_wb_regwrite", 32'(regwrite), 32'd1);
      chk("lw_wb_memtoreg", 32'(memtoreg), 32'd1);
      chk("lw_wb_destreg", 32'(destreg), 32'd5);

      // beq taken then not taken
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      chk("beq_z1_dobranch", 32'(dobranch), 32'd1);
      chk("beq_z1_alucontrol", 32'(alucontrol), 32'b001);
      cyc(1'b0, 1'b1, 1'b0);
      chk("beq_back_in_fetch", 32'(irwrite), 32'd1);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("beq_z0_dobranch", 32'(dobranch), 32'd0);

      // jal
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("jal_dojump", 32'(dojump), 32'd1);
      chk("jal_regwrite", 32'(regwrite), 32'd1);
      chk("jal_destreg", 32'(destreg), 32'd31);
      chk("jal_linksel", 32'(linksel), 32'd1);

      // illegal opcode 0x3F
      cyc(1'b0, 1'b1, 1'b0);
      chk("jal_next_is_fetch", 32'(memread), 32'd1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("illegal_pulse", 32'(illegal), 32'd1);

      // fetch timeout: first of 16 waiting cycles here
      cyc(1'b0, 1'b0, 1'b0);
      chk("illegal_pulse_ends", 32'(illegal), 32'd0);
      for (int i = 2; i <= 16; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (i == 15) chk("timeout_not_early", 32'(buserr), 32'd0);
      end
      chk("timeout_buserr", 32'(buserr), 32'd1);
      chk("timeout_no_irwrite", 32'(irwrite), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("timeout_retry_fetch", 32'({memread, buserr}), 32'b10);

      // sw aborted by reset in MEM
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("sw_mem_memwrite", 32'(memwrite), 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("sw_reset_memwrite", 32'(memwrite), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("sw_reset_to_fetch", 32'({memread, memwrite}), 32'b10);

      for (int i = 0; i < 3000; i++) begin
         logic r, mr;
         r = ($urandom_range(0, 199) == 0);
         if (burst > 0) begin
            mr = 1'b0;
            burst--;
         end else if ($urandom_range(0, 39) == 0) begin
            burst = $urandom_range(5, 20);
            mr    = 1'b0;
         end else begin
            mr = ($urandom_range(0, 3) != 0);
         end
         cyc(r, mr, ($urandom_range(0, 1) == 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
